para_regs_mc: RTL

- Parametrised, multi-channel successor to the single-device parameter block on the fx bus.
- Holds per-channel control and threshold registers, written and read over the fx byte bus.
- Monitors NUM_CH parallel AD channels: last sample, running peak, saturating over-threshold count.
- Sits between the fx bus decoder and the AD front end; one instance per board device, selected by dev_id.

---
 rtl/para_regs_mc.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/para_regs_mc.sv
// para_regs_mc: multi-channel fx-bus parameter block with per-channel AD monitors.
// Optional build macro PARA_REGS_MC_IRQ_EN adds the irq output and CTRL bit2 (IE).
module para_regs_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned AD_W   = 12,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic [7:0]             dev_id,
    input  logic [NUM_CH*AD_W-1:0] ad_data,
    input  logic                   ad_vld,
    input  logic                   fx_wr,
    input  logic [21:0]            fx_waddr,
    input  logic [7:0]             fx_data,
    input  logic                   fx_rd,
    input  logic [21:0]            fx_raddr,
`ifdef PARA_REGS_MC_IRQ_EN
    output logic                   irq,
`endif
    output logic [7:0]             fx_q
);

    localparam int unsigned CH_W   = 4;
    localparam int unsigned BYTE_W = 8;
    localparam logic [CH_W-1:0] GLOBAL_CH = 4'hF;

    logic              w_sel, r_sel;
    logic [CH_W-1:0]   w_ch, w_reg, r_ch, r_reg;

    logic [BYTE_W-1:0] fx_q_q, fx_q_d, rdata_c;
    logic [BYTE_W-1:0] scratch_q, scratch_d;

    logic              en_q        [NUM_CH];
    logic              en_d        [NUM_CH];
    logic              clr_c       [NUM_CH];
    logic [BYTE_W-1:0] thr_lo_q    [NUM_CH];
    logic [BYTE_W-1:0] thr_lo_d    [NUM_CH];
    logic [BYTE_W-1:0] thr_hi_q    [NUM_CH];
    logic [BYTE_W-1:0] thr_hi_d    [NUM_CH];
    logic [AD_W-1:0]   thr_q       [NUM_CH];
    logic [AD_W-1:0]   thr_d       [NUM_CH];
    logic [AD_W-1:0]   last_q      [NUM_CH];
    logic [AD_W-1:0]   last_d      [NUM_CH];
    logic [AD_W-1:0]   peak_q      [NUM_CH];
    logic [AD_W-1:0]   peak_d      [NUM_CH];
    logic [CNT_W-1:0]  cnt_q       [NUM_CH];
    logic [CNT_W-1:0]  cnt_d       [NUM_CH];
    logic [BYTE_W-1:0] hold_last_q [NUM_CH];
    logic [BYTE_W-1:0] hold_last_d [NUM_CH];
    logic [BYTE_W-1:0] hold_peak_q [NUM_CH];
    logic [BYTE_W-1:0] hold_peak_d [NUM_CH];
`ifdef PARA_REGS_MC_IRQ_EN
    logic              ie_q        [NUM_CH];
    logic              ie_d        [NUM_CH];
    logic              pend_q      [NUM_CH];
    logic              pend_d      [NUM_CH];
    logic              irq_q, irq_d;
`endif

    // Address decode: device match and addr[13:8] must be zero
    assign w_sel = fx_wr && (fx_waddr[21:14] == dev_id) && (fx_waddr[13:8] == 6'd0);
    assign r_sel = fx_rd && (fx_raddr[21:14] == dev_id) && (fx_raddr[13:8] == 6'd0);
    assign w_ch  = fx_waddr[7:4];
    assign w_reg = fx_waddr[3:0];
    assign r_ch  = fx_raddr[7:4];
    assign r_reg = fx_raddr[3:0];

    // Read mux; reads see pre-write state, holds are captured on the L-byte read
    always_comb begin
        rdata_c = 8'h00;
        if (r_sel) begin
            if (r_ch == GLOBAL_CH) begin
                case (r_reg)
                    4'd0:    rdata_c = 8'(NUM_CH);
                    4'd1:    rdata_c = 8'(AD_W);
                    4'd2:    rdata_c = scratch_q;
                    default: rdata_c = 8'h00;
                endcase
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (r_ch == CH_W'(c)) begin
                        case (r_reg)
`ifdef PARA_REGS_MC_IRQ_EN
                            4'd0:    rdata_c = {5'd0, ie_q[c], 1'b0, en_q[c]};
`else
                            4'd0:    rdata_c = {7'd0, en_q[c]};
`endif
                            4'd1:    rdata_c = thr_lo_q[c];
                            4'd2:    rdata_c = thr_hi_q[c];
                            4'd4:    rdata_c = last_q[c][7:0];
                            4'd5:    rdata_c = hold_last_q[c];
                            4'd6:    rdata_c = peak_q[c][7:0];
                            4'd7:    rdata_c = hold_peak_q[c];
                            4'd8:    rdata_c = 8'(cnt_q[c]);
                            default: rdata_c = 8'h00;
                        endcase
                    end
                end
            end
        end
        fx_q_d = fx_rd ? rdata_c : fx_q_q;
    end

    // Next-state for registers and per-channel monitors
    always_comb begin
        scratch_d = scratch_q;
        if (w_sel && (w_ch == GLOBAL_CH) && (w_reg == 4'd2)) begin
            scratch_d = fx_data;
        end
`ifdef PARA_REGS_MC_IRQ_EN
        irq_d = 1'b0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            en_d[c]        = en_q[c];
            clr_c[c]       = 1'b0;
            thr_lo_d[c]    = thr_lo_q[c];
            thr_hi_d[c]    = thr_hi_q[c];
            thr_d[c]       = thr_q[c];
            last_d[c]      = last_q[c];
            peak_d[c]      = peak_q[c];
            cnt_d[c]       = cnt_q[c];
            hold_last_d[c] = hold_last_q[c];
            hold_peak_d[c] = hold_peak_q[c];
`ifdef PARA_REGS_MC_IRQ_EN
            ie_d[c]        = ie_q[c];
            pend_d[c]      = pend_q[c];
`endif
            if (w_sel && (w_ch == CH_W'(c))) begin
                case (w_reg)
                    4'd0: begin
                        en_d[c]  = fx_data[0];
                        clr_c[c] = fx_data[1];
`ifdef PARA_REGS_MC_IRQ_EN
                        ie_d[c]  = fx_data[2];
`endif
                    end
                    4'd1: thr_lo_d[c] = fx_data;
                    4'd2: begin
                        thr_hi_d[c] = fx_data;
                        thr_d[c]    = AD_W'({fx_data, thr_lo_q[c]});
                    end
                    default: ;
                endcase
            end
            // Sample update, then CLR overrides PEAK and CNT
            if (ad_vld && en_q[c]) begin
                last_d[c] = ad_data[c*AD_W +: AD_W];
                if (ad_data[c*AD_W +: AD_W] > peak_q[c]) begin
                    peak_d[c] = ad_data[c*AD_W +: AD_W];
                end
                if ((ad_data[c*AD_W +: AD_W] > thr_q[c]) && (cnt_q[c] != '1)) begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
            if (clr_c[c]) begin
                peak_d[c] = '0;
                cnt_d[c]  = '0;
            end
            if (r_sel && (r_ch == CH_W'(c))) begin
                if (r_reg == 4'd4) hold_last_d[c] = 8'(last_q[c][AD_W-1:8]);
                if (r_reg == 4'd6) hold_peak_d[c] = 8'(peak_q[c][AD_W-1:8]);
            end
`ifdef PARA_REGS_MC_IRQ_EN
            if (ie_q[c] && (cnt_q[c] == '0) && (cnt_d[c] != '0)) pend_d[c] = 1'b1;
            if (clr_c[c]) pend_d[c] = 1'b0;
            irq_d = irq_d | pend_d[c];
`endif
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            fx_q_q    <= '0;
            scratch_q <= '0;
`ifdef PARA_REGS_MC_IRQ_EN
            irq_q     <= 1'b0;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                en_q[c]        <= 1'b0;
                thr_lo_q[c]    <= '0;
                thr_hi_q[c]    <= '0;
                thr_q[c]       <= '1;
                last_q[c]      <= '0;
                peak_q[c]      <= '0;
                cnt_q[c]       <= '0;
                hold_last_q[c] <= '0;
                hold_peak_q[c] <= '0;
`ifdef PARA_REGS_MC_IRQ_EN
                ie_q[c]        <= 1'b0;
                pend_q[c]      <= 1'b0;
`endif
            end
        end else begin
            fx_q_q    <= fx_q_d;
            scratch_q <= scratch_d;
`ifdef PARA_REGS_MC_IRQ_EN
            irq_q     <= irq_d;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                en_q[c]        <= en_d[c];
                thr_lo_q[c]    <= thr_lo_d[c];
                thr_hi_q[c]    <= thr_hi_d[c];
                thr_q[c]       <= thr_d[c];
                last_q[c]      <= last_d[c];
                peak_q[c]      <= peak_d[c];
                cnt_q[c]       <= cnt_d[c];
                hold_last_q[c] <= hold_last_d[c];
                hold_peak_q[c] <= hold_peak_d[c];
`ifdef PARA_REGS_MC_IRQ_EN
                ie_q[c]        <= ie_d[c];
                pend_q[c]      <= pend_d[c];
`endif
            end
        end
    end

    assign fx_q = fx_q_q;
`ifdef PARA_REGS_MC_IRQ_EN
    assign irq  = irq_q;
`endif

endmodule
